bcd_countdown_timer: RTL and testbench
======================================

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have ports: clk, input, 1, clock, all logic on rising edge.
REQ-002 SHALL have ports: reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have ports: tick, input, 1, one-cycle 1 Hz decrement enable.
REQ-004 SHALL have ports: load, input, 1, load preset from load_hh/load_mm/load_ss.
REQ-005 SHALL have ports: load_hh / load_mm / load_ss, input, 8 each, BCD preset {tens,units}.
REQ-006 SHALL have ports: start, input, 1, begin or resume countdown.
REQ-007 SHALL have ports: pause, input, 1, hold countdown.
REQ-008 SHALL have ports: clear, input, 1, abort and zero.
REQ-009 SHALL have ports: hh / mm / ss, output, 8 each, current BCD remaining time.
REQ-010 SHALL have ports: running, output, 1, high while in RUN.
REQ-011 SHALL have ports: expired, output, 1, one-cycle pulse on reaching 00:00:00.
REQ-012 SHALL have ports: load_err, output, 1, one-cycle pulse on rejected load.
REQ-013 SHALL have parameter HH_MAX, default 8'h23, BCD upper limit for load_hh.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSED, DONE; all outputs registered.
REQ-015 SHALL evaluate controls by priority clear > load > pause > start > tick.
REQ-016 SHALL on clear, from any state, set count 00:00:00 and go IDLE next cycle.
REQ-017 SHALL accept load only in IDLE, PAUSED or DONE, and only if every digit is at most 9, mm/ss tens at most 5, and hh at most HH_MAX.
REQ-018 SHALL on an accepted load, copy the preset to hh/mm/ss next cycle and go IDLE.
REQ-019 SHALL on a load in RUN or an invalid preset, leave count and state unchanged and pulse load_err for one cycle.
REQ-020 SHALL on start in IDLE or PAUSED with count nonzero, enter RUN next cycle; start at 00:00:00 or in RUN/DONE is ignored.
REQ-021 SHALL on pause in RUN, enter PAUSED; pause elsewhere is ignored; pause with tick in RUN means no decrement.
REQ-022 SHALL in RUN on tick, decrement count by one second, visible next cycle; ticks outside RUN are ignored.
REQ-023 SHALL follow these decrement borrow rules: ss units 0 -> 9, with borrow into ss tens; ss tens 0 -> 5, with borrow into mm; mm the same as ss, with borrow into hh; hh units 0 -> 9, with borrow into hh tens.
REQ-024 SHALL on tick in RUN at 00:00:01, present 00:00:00, enter DONE and assert expired for exactly that cycle.
REQ-025 SHALL hold count at 00:00:00 in DONE; no underflow ever; expired not re-asserted.
REQ-026 SHALL assert running = (state == RUN).

Reset
REQ-027 SHALL on reset: state IDLE, hh=mm=ss=8'h00, running=0, expired=0, load_err=0.
REQ-028 SHALL give reset priority over all inputs, including mid-countdown; no pending pulse survives reset.

Structure
REQ-029 SHALL place the state enum, BCD digit limit constants (9, 5) and the zero-time constant in package bcd_timer_pkg.
REQ-030 SHALL implement each digit with sub-module bcd_digit_down (inputs: dec enable, load, load value, wrap value; outputs: digit, borrow-out when decrementing at 0), instantiated six times.

Verification
REQ-031 SHALL verify: reset then load 00:01:00, start, 1 tick -> 00:00:59; 59 more ticks -> 00:00:00, expired pulse once, state DONE.
REQ-032 SHALL verify: load 10:00:00, start, 1 tick -> 09:59:59, running=1.
REQ-033 SHALL verify: load 8'h24 as hh, then load mm 8'h60, then load nibble 4'hA -> each pulses load_err, count unchanged.
REQ-034 SHALL verify: RUN at 00:00:05, pause+tick same cycle -> 00:00:05, PAUSED; 3 ticks -> unchanged; start, 1 tick -> 00:00:04.
REQ-035 SHALL verify: load during RUN -> load_err=1, countdown continues; clear at 00:00:02 -> 00:00:00, IDLE, no expired.
REQ-036 SHALL verify: reset asserted mid-RUN at 01:23:45 -> next cycle 00:00:00, running=0; start at zero count -> stays IDLE.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the FSM encoding, digit limits and time constants.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0]  DIGIT_MAX = 4'd9;
    localparam logic [3:0]  TENS_MAX  = 4'd5;
    localparam logic [23:0] ZERO_TIME = 24'h00_00_00;
    localparam logic [23:0] ONE_SEC   = 24'h00_00_01;

    // Two-digit BCD field check with a caller-chosen tens limit.
    function automatic logic bcd_ok(input logic [7:0] v,
                                    input logic [3:0] tens_max);
        return (v[3:0] <= DIGIT_MAX) && (v[7:4] <= tens_max);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with load and wrap-on-borrow.
// Borrow is raised combinationally when decrementing from zero.
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [3:0] wrap_val,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] digit_d;
    logic [3:0] digit_q;

    // Next digit: load wins, otherwise decrement with wrap.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec) begin
            if (digit_q == 4'd0) begin
                digit_d = wrap_val;
            end else begin
                digit_d = digit_q - 4'd1;
            end
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign borrow = dec && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// HH:MM:SS BCD countdown timer with load, start, pause and clear.
// Six chained BCD digits; control FSM sets priority and pulses.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter logic [7:0] HH_MAX = 8'h23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       expired,
    output logic       load_err
);

    state_e      state_d, state_q;
    logic        running_d, running_q;
    logic        expired_d, expired_q;
    logic        load_err_d, load_err_q;

    logic        dec;
    logic        dig_load;
    logic [23:0] load_vec;
    logic [23:0] cnt;
    logic [6:0]  chain;
    logic        preset_ok;
    logic        is_zero;
    logic        is_one;
    logic        unused_borrow;

    assign is_zero = (cnt == ZERO_TIME);
    assign is_one  = (cnt == ONE_SEC);

    assign preset_ok = bcd_ok(load_hh, DIGIT_MAX)
                    && (load_hh <= HH_MAX)
                    && bcd_ok(load_mm, TENS_MAX)
                    && bcd_ok(load_ss, TENS_MAX);

    // Control FSM: clear > load > pause > start > tick.
    always_comb begin
        state_d    = state_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
        dec        = 1'b0;
        dig_load   = 1'b0;
        load_vec   = ZERO_TIME;
        if (clear) begin
            dig_load = 1'b1;
            state_d  = IDLE;
        end else if (load) begin
            if (state_q != RUN && preset_ok) begin
                dig_load = 1'b1;
                load_vec = {load_hh, load_mm, load_ss};
                state_d  = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pause && state_q == RUN) begin
            state_d = PAUSED;
        end else if (start && !is_zero
                     && (state_q == IDLE || state_q == PAUSED)) begin
            state_d = RUN;
        end else if (tick && state_q == RUN) begin
            dec = 1'b1;
            if (is_one) begin
                state_d   = DONE;
                expired_d = 1'b1;
            end
        end
        running_d = (state_d == RUN);
    end

    // State and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign chain[0] = dec;

    // Digit 0 is seconds units; tens of mm/ss wrap to 5.
    for (genvar i = 0; i < 6; i++) begin : g_dig
        localparam logic [3:0] WRAP =
            (i == 1 || i == 3) ? TENS_MAX : DIGIT_MAX;
        bcd_digit_down u_dig (
            .clk      (clk),
            .reset    (reset),
            .dec      (chain[i]),
            .load     (dig_load),
            .load_val (load_vec[4*i +: 4]),
            .wrap_val (WRAP),
            .digit    (cnt[4*i +: 4]),
            .borrow   (chain[i+1])
        );
    end

    // Never set: decrement is blocked at zero.
    assign unused_borrow = chain[6];

    assign hh       = cnt[23:16];
    assign mm       = cnt[15:8];
    assign ss       = cnt[7:0];
    assign running  = running_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer: directed scenarios plus
// random stimulus against a seconds-based reference model.
module tb_bcd_countdown_timer;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_DONE   = 3;
    localparam int HH_LIMIT = 23;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_hh = 8'h00;
    logic [7:0] load_mm = 8'h00;
    logic [7:0] load_ss = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] hh, mm, ss;
    logic       running, expired, load_err;

    int checks = 0;
    int failures = 0;
    int exp_seen = 0;

    int m_secs = 0;
    int m_st = S_IDLE;
    bit m_exp = 1'b0;
    bit m_err = 1'b0;

    bcd_countdown_timer #(.HH_MAX(8'h23)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_hh  (load_hh),
        .load_mm  (load_mm),
        .load_ss  (load_ss),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .running  (running),
        .expired  (expired),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want,
                     $time);
        end
    endtask

    function automatic int nib(input logic [7:0] v, input int hi);
        return hi != 0 ? int'(v[7:4]) : int'(v[3:0]);
    endfunction

    function automatic bit field_ok(input logic [7:0] v, input int tmax);
        return nib(v, 0) <= 9 && nib(v, 1) <= tmax;
    endfunction

    function automatic int field_val(input logic [7:0] v);
        return nib(v, 1) * 10 + nib(v, 0);
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(x / 10), 4'(x % 10)};
    endfunction

    // Reference behaviour computed in whole seconds.
    task automatic model_update();
        bit ok;
        m_exp = 1'b0;
        m_err = 1'b0;
        ok = field_ok(load_hh, 9) && field_ok(load_mm, 5)
             && field_ok(load_ss, 5)
             && field_val(load_hh) <= HH_LIMIT;
        if (reset || clear) begin
            m_secs = 0;
            m_st = S_IDLE;
        end else if (load) begin
            if (m_st != S_RUN && ok) begin
                m_secs = field_val(load_hh) * 3600
                       + field_val(load_mm) * 60 + field_val(load_ss);
                m_st = S_IDLE;
            end else begin
                m_err = 1'b1;
            end
        end else if (pause && m_st == S_RUN) begin
            m_st = S_PAUSED;
        end else if (start && m_secs != 0
                     && (m_st == S_IDLE || m_st == S_PAUSED)) begin
            m_st = S_RUN;
        end else if (tick && m_st == S_RUN) begin
            m_secs--;
            if (m_secs == 0) begin
                m_st = S_DONE;
                m_exp = 1'b1;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("count", {8'h00, hh, mm, ss}, {8'h00, to_bcd(m_secs)});
        chk("running", 32'(running), 32'(m_st == S_RUN));
        chk("expired", 32'(expired), 32'(m_exp));
        chk("load_err", 32'(load_err), 32'(m_err));
        exp_seen += int'(expired);
        reset = 1'b0;
        clear = 1'b0;
        load = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        tick = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s);
        load = 1'b1;
        load_hh = h;
        load_mm = m;
        load_ss = s;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
    endtask

    initial begin
        // Reset then one-minute countdown to expiry.
        do_reset();
        chk("rst_cnt", {8'h00, hh, mm, ss}, 32'h0);
        chk("rst_run", 32'(running), 32'h0);
        do_load(8'h00, 8'h01, 8'h00);
        do_start();
        do_ticks(1);
        chk("min_59", {8'h00, hh, mm, ss}, 32'h000059);
        exp_seen = 0;
        do_ticks(59);
        chk("min_zero", {8'h00, hh, mm, ss}, 32'h000000);
        chk("min_exp_once", 32'(exp_seen), 32'd1);
        do_ticks(3);
        do_start();
        chk("done_hold", {8'h00, hh, mm, ss}, 32'h000000);
        chk("done_run", 32'(running), 32'h0);
        chk("done_exp_once", 32'(exp_seen), 32'd1);

        // Full borrow across hours.
        do_load(8'h10, 8'h00, 8'h00);
        do_start();
        do_ticks(1);
        chk("hr_borrow", {8'h00, hh, mm, ss}, 32'h095959);
        chk("hr_run", 32'(running), 32'h1);

        // Rejected presets leave the count alone.
        do_clear();
        do_load(8'h12, 8'h34, 8'h56);
        do_load(8'h24, 8'h00, 8'h00);
        chk("err_hh", 32'(load_err), 32'h1);
        chk("err_hh_cnt", {8'h00, hh, mm, ss}, 32'h123456);
        do_load(8'h00, 8'h60, 8'h00);
        chk("err_mm", 32'(load_err), 32'h1);
        do_load(8'h00, 8'h00, 8'h0A);
        chk("err_nib", 32'(load_err), 32'h1);
        chk("err_nib_cnt", {8'h00, hh, mm, ss}, 32'h123456);

        // Pause with tick in the same cycle.
        do_load(8'h00, 8'h00, 8'h05);
        do_start();
        pause = 1'b1;
        tick = 1'b1;
        step();
        chk("pause_cnt", {8'h00, hh, mm, ss}, 32'h000005);
        chk("pause_run", 32'(running), 32'h0);
        do_ticks(3);
        chk("pause_hold", {8'h00, hh, mm, ss}, 32'h000005);
        do_start();
        do_ticks(1);
        chk("resume", {8'h00, hh, mm, ss}, 32'h000004);

        // Load during RUN, then clear before expiry.
        do_load(8'h00, 8'h00, 8'h30);
        chk("run_ld_err", 32'(load_err), 32'h1);
        chk("run_ld_run", 32'(running), 32'h1);
        do_ticks(2);
        chk("run_two", {8'h00, hh, mm, ss}, 32'h000002);
        exp_seen = 0;
        do_clear();
        chk("clr_cnt", {8'h00, hh, mm, ss}, 32'h000000);
        chk("clr_run", 32'(running), 32'h0);
        do_ticks(2);
        chk("clr_no_exp", 32'(exp_seen), 32'd0);

        // Reset mid-run, then start at zero.
        do_load(8'h01, 8'h23, 8'h45);
        do_start();
        do_reset();
        chk("mid_rst_cnt", {8'h00, hh, mm, ss}, 32'h000000);
        chk("mid_rst_run", 32'(running), 32'h0);
        do_start();
        chk("zero_start", 32'(running), 32'h0);

        // Random stimulus against the model.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(299) == 0);
            clear = ($urandom_range(99) == 0);
            load = ($urandom_range(19) == 0);
            pause = ($urandom_range(15) == 0);
            start = ($urandom_range(7) == 0);
            tick = ($urandom_range(2) != 0);
            if ($urandom_range(3) != 0) begin
                load_hh = 8'h00;
                load_mm = 8'($urandom_range(1));
                load_ss = {4'($urandom_range(5)), 4'($urandom_range(9))};
            end else begin
                load_hh = 8'($urandom_range(255));
                load_mm = 8'($urandom_range(255));
                load_ss = 8'($urandom_range(255));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
